// File: rtl/dispatch_queue_if.sv
// Bus bundle for dispatch_queue: decoder input, RF/ROB lookups, CDB snoop and
// the registered dispatch outputs toward ROB, RS and LSB.
interface dispatch_queue_if #(
  parameter int DATA_W  = 32,
  parameter int ROB_W   = 4,
  parameter int REG_W   = 5,
  parameter int OPT_W   = 6,
  parameter int NUM_CDB = 2
);
  logic                      in_valid, in_ready;
  logic [OPT_W-1:0]          in_inst_type;
  logic [REG_W-1:0]          in_rd, in_rs1, in_rs2;
  logic [DATA_W-1:0]         in_imm, in_pc;
  logic                      in_pred_jump, in_is_ls, in_is_btype;
  logic                      rob_full, rs_full, lsb_full;
  logic [ROB_W-1:0]          cur_alias_from_rob;
  logic [REG_W-1:0]          rs1_to_rf, rs2_to_rf;
  logic [DATA_W-1:0]         Vi_from_rf, Vj_from_rf;
  logic [ROB_W-1:0]          Qi_from_rf, Qj_from_rf;
  logic [ROB_W-1:0]          qi_to_rob, qj_to_rob;
  logic                      Vi_valid_from_rob, Vj_valid_from_rob;
  logic [DATA_W-1:0]         Vi_from_rob, Vj_from_rob;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*ROB_W-1:0]  cdb_alias;
  logic [NUM_CDB*DATA_W-1:0] cdb_value;
  logic                      rob_valid, rob_is_btype, rob_pred_jump;
  logic [DATA_W-1:0]         rob_pc;
  logic [REG_W-1:0]          rob_rd;
  logic [OPT_W-1:0]          rob_inst_type;
  logic                      rename_valid;
  logic [REG_W-1:0]          rename_reg;
  logic [ROB_W-1:0]          rename_alias;
  logic                      rs_valid, lsb_valid;
  logic [ROB_W-1:0]          iss_alias, iss_Qi, iss_Qj;
  logic [OPT_W-1:0]          iss_inst_type;
  logic [DATA_W-1:0]         iss_Vi, iss_Vj, iss_imm, iss_pc;

  modport slave (
    input  in_valid, in_inst_type, in_rd, in_rs1, in_rs2, in_imm, in_pc,
           in_pred_jump, in_is_ls, in_is_btype, rob_full, rs_full, lsb_full,
           cur_alias_from_rob, Vi_from_rf, Vj_from_rf, Qi_from_rf, Qj_from_rf,
           Vi_valid_from_rob, Vj_valid_from_rob, Vi_from_rob, Vj_from_rob,
           cdb_valid, cdb_alias, cdb_value,
    output in_ready, rs1_to_rf, rs2_to_rf, qi_to_rob, qj_to_rob,
           rob_valid, rob_pc, rob_rd, rob_is_btype, rob_pred_jump, rob_inst_type,
           rename_valid, rename_reg, rename_alias, rs_valid, lsb_valid,
           iss_alias, iss_inst_type, iss_Vi, iss_Vj, iss_Qi, iss_Qj, iss_imm, iss_pc
  );

  modport master (
    output in_valid, in_inst_type, in_rd, in_rs1, in_rs2, in_imm, in_pc,
           in_pred_jump, in_is_ls, in_is_btype, rob_full, rs_full, lsb_full,
           cur_alias_from_rob, Vi_from_rf, Vj_from_rf, Qi_from_rf, Qj_from_rf,
           Vi_valid_from_rob, Vj_valid_from_rob, Vi_from_rob, Vj_from_rob,
           cdb_valid, cdb_alias, cdb_value,
    input  in_ready, rs1_to_rf, rs2_to_rf, qi_to_rob, qj_to_rob,
           rob_valid, rob_pc, rob_rd, rob_is_btype, rob_pred_jump, rob_inst_type,
           rename_valid, rename_reg, rename_alias, rs_valid, lsb_valid,
           iss_alias, iss_inst_type, iss_Vi, iss_Vj, iss_Qi, iss_Qj, iss_imm, iss_pc
  );
endinterface

// File: rtl/dispatch_queue.sv
// In-order single-issue dispatcher behind a DEPTH-entry FIFO; 2-cycle in_valid->rob_valid.
// Head waits on rob_full and on rs_full/lsb_full of its own unit; in_ready drops when full.
module dispatch_queue #(
  parameter int DATA_W  = 32,
  parameter int ROB_W   = 4,
  parameter int REG_W   = 5,
  parameter int OPT_W   = 6,
  parameter int DEPTH   = 4,
  parameter int NUM_CDB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            rollback,
  dispatch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [OPT_W-1:0]  inst_type;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic              pred_jump;
    logic              is_ls;
    logic              is_btype;
  } entry_t;

  typedef struct packed {
    logic [ROB_W-1:0]  q;
    logic [DATA_W-1:0] v;
  } opnd_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head_ptr, tail_ptr;
  logic [CW-1:0]   count;
  entry_t          head, in_entry;
  logic            accept, go, byp_i, byp_j;
  logic [ROB_W-1:0] qi_eff, qj_eff;
  opnd_t           op_i, op_j;

  // A bypass hit never takes the RF value directly: the producer is still in flight.
  function automatic opnd_t resolve(
    input logic [REG_W-1:0]          rs,
    input logic                      byp,
    input logic [ROB_W-1:0]          q_eff,
    input logic [DATA_W-1:0]         v_rf,
    input logic                      rob_hit,
    input logic [DATA_W-1:0]         v_rob,
    input logic [NUM_CDB-1:0]        c_valid,
    input logic [NUM_CDB*ROB_W-1:0]  c_alias,
    input logic [NUM_CDB*DATA_W-1:0] c_value
  );
    opnd_t             r;
    logic              cdb_hit;
    logic [DATA_W-1:0] cdb_v;
    cdb_hit = 1'b0;
    cdb_v   = '0;
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (c_valid[i] && c_alias[i*ROB_W +: ROB_W] == q_eff) begin
        cdb_hit = 1'b1;
        cdb_v   = c_value[i*DATA_W +: DATA_W];
      end
    end
    r.q = q_eff;
    r.v = '0;
    if (rs == '0) begin
      r.q = '0;
    end else if (!byp && q_eff == '0) begin
      r.v = v_rf;
    end else if (cdb_hit) begin
      r.q = '0;
      r.v = cdb_v;
    end else if (rob_hit) begin
      r.q = '0;
      r.v = v_rob;
    end
    return r;
  endfunction

  assign head     = mem[head_ptr];
  assign in_entry = '{inst_type: bus.in_inst_type, rd: bus.in_rd, rs1: bus.in_rs1,
                      rs2: bus.in_rs2, imm: bus.in_imm, pc: bus.in_pc,
                      pred_jump: bus.in_pred_jump, is_ls: bus.in_is_ls,
                      is_btype: bus.in_is_btype};

  assign bus.in_ready = (count < CW'(DEPTH)) & ~rollback;
  assign accept       = bus.in_valid & bus.in_ready & rdy;
  assign go = (count != '0) & rdy & ~rollback & ~bus.rob_full &
              (head.is_ls ? ~bus.lsb_full : ~bus.rs_full);

  assign byp_i  = bus.rename_valid & (bus.rename_reg == head.rs1) & (head.rs1 != '0);
  assign byp_j  = bus.rename_valid & (bus.rename_reg == head.rs2) & (head.rs2 != '0);
  assign qi_eff = (head.rs1 == '0) ? '0 : (byp_i ? bus.rename_alias : bus.Qi_from_rf);
  assign qj_eff = (head.rs2 == '0) ? '0 : (byp_j ? bus.rename_alias : bus.Qj_from_rf);

  assign bus.rs1_to_rf = head.rs1;
  assign bus.rs2_to_rf = head.rs2;
  assign bus.qi_to_rob = qi_eff;
  assign bus.qj_to_rob = qj_eff;

  assign op_i = resolve(head.rs1, byp_i, qi_eff, bus.Vi_from_rf, bus.Vi_valid_from_rob,
                        bus.Vi_from_rob, bus.cdb_valid, bus.cdb_alias, bus.cdb_value);
  assign op_j = resolve(head.rs2, byp_j, qj_eff, bus.Vj_from_rf, bus.Vj_valid_from_rob,
                        bus.Vj_from_rob, bus.cdb_valid, bus.cdb_alias, bus.cdb_value);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head_ptr          <= '0;
      tail_ptr          <= '0;
      count             <= '0;
      bus.rob_valid     <= 1'b0;
      bus.rob_pc        <= '0;
      bus.rob_rd        <= '0;
      bus.rob_is_btype  <= 1'b0;
      bus.rob_pred_jump <= 1'b0;
      bus.rob_inst_type <= '0;
      bus.rename_valid  <= 1'b0;
      bus.rename_reg    <= '0;
      bus.rename_alias  <= '0;
      bus.rs_valid      <= 1'b0;
      bus.lsb_valid     <= 1'b0;
      bus.iss_alias     <= '0;
      bus.iss_inst_type <= '0;
      bus.iss_Vi        <= '0;
      bus.iss_Vj        <= '0;
      bus.iss_Qi        <= '0;
      bus.iss_Qj        <= '0;
      bus.iss_imm       <= '0;
      bus.iss_pc        <= '0;
    end else if (rollback) begin
      head_ptr         <= '0;
      tail_ptr         <= '0;
      count            <= '0;
      bus.rob_valid    <= 1'b0;
      bus.rename_valid <= 1'b0;
      bus.rs_valid     <= 1'b0;
      bus.lsb_valid    <= 1'b0;
    end else if (rdy) begin
      if (accept) begin
        mem[tail_ptr] <= in_entry;
        tail_ptr      <= tail_ptr + 1'b1;
      end
      if (go) head_ptr <= head_ptr + 1'b1;
      case ({accept, go})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      bus.rob_valid    <= go;
      bus.rs_valid     <= go & ~head.is_ls;
      bus.lsb_valid    <= go & head.is_ls;
      bus.rename_valid <= go & (head.rd != '0);
      if (go) begin
        bus.rob_pc        <= head.pc;
        bus.rob_rd        <= head.rd;
        bus.rob_is_btype  <= head.is_btype;
        bus.rob_pred_jump <= head.pred_jump;
        bus.rob_inst_type <= head.inst_type;
        bus.rename_reg    <= head.rd;
        bus.rename_alias  <= bus.cur_alias_from_rob;
        bus.iss_alias     <= bus.cur_alias_from_rob;
        bus.iss_inst_type <= head.inst_type;
        bus.iss_Vi        <= op_i.v;
        bus.iss_Vj        <= op_j.v;
        bus.iss_Qi        <= op_i.q;
        bus.iss_Qj        <= op_j.q;
        bus.iss_imm       <= head.imm;
        bus.iss_pc        <= head.pc;
      end
    end
  end
endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised single-issue dispatcher with an input instruction queue. It sits between the decoder and the ROB / reservation station / load-store buffer and decouples decode from back-end stalls with a DEPTH-entry FIFO. Each instruction gets separate backpressure per destination unit and operand capture from NUM_CDB broadcast channels. An internal rename bypass covers back-to-back dependent instructions.

## Interface
- DATA_W, 32, data/pc/imm width
- ROB_W, 4, alias width; alias 0 = "no dependency", never allocated
- REG_W, 5, architectural register index width
- OPT_W, 6, inst_type width
- DEPTH, 4, queue entries, power of 2, ≥2
- NUM_CDB, 2, broadcast channels; channel 0 = ALU, 1 = LSB by convention
- clk  in  1  clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; low freezes all state
- rollback  in  1  synchronous flush
- in_valid, in_ready  in/out  1  decoder handshake
- in_inst_type, in_rd, in_rs1, in_rs2, in_imm, in_pc, in_pred_jump, in_is_ls, in_is_btype  in  OPT_W/REG_W/REG_W/REG_W/DATA_W/DATA_W/1/1/1  decoded fields
- rob_full, rs_full, lsb_full  in  1  per-unit stall
- cur_alias_from_rob  in  ROB_W  alias for the next allocation
- rs1_to_rf, rs2_to_rf  out  REG_W  combinational; head sources
- Vi_from_rf, Vj_from_rf / Qi_from_rf, Qj_from_rf  in  DATA_W / ROB_W
- qi_to_rob, qj_to_rob  out  ROB_W  combinational; effective tags
- Vi_valid_from_rob, Vj_valid_from_rob / Vi_from_rob, Vj_from_rob  in  1 / DATA_W
- cdb_valid  in  NUM_CDB;  cdb_alias  in  NUM_CDB*ROB_W;  cdb_value  in  NUM_CDB*DATA_W
- rob_valid, rob_pc, rob_rd, rob_is_btype, rob_pred_jump, rob_inst_type  out  registered
- rename_valid, rename_reg, rename_alias  out  registered
- rs_valid, lsb_valid  out  1  registered
- shared issue bus: iss_alias, iss_inst_type, iss_Vi, iss_Vj, iss_Qi, iss_Qj, iss_imm, iss_pc  out  registered

## Operation
- FIFO: head/tail pointers of log2(DEPTH) bits with wrap, count of log2(DEPTH)+1 bits. in_ready = (count < DEPTH) & ~rollback.
- Accept when in_valid & in_ready & rdy.
- Head dispatchable (go) when count>0 & rdy & ~rollback & ~rob_full & (in_is_ls ? ~lsb_full : ~rs_full) of the head entry.
- Accept and go in the same cycle: count is unchanged, both pointers advance.
- Effective tag, Qi shown; Qj is symmetric with rs2:
  - Qi_eff = (rename_valid & rename_reg==head.rs1 & head.rs1!=0) ? rename_alias : Qi_from_rf.
  - head.rs1==0 forces Qi_eff=0 and Vi=0.
  - qi_to_rob = Qi_eff.
- Operand resolution, first hit wins:
  - Qi_eff==0 → Vi_from_rf, unless the bypass hit (then the ROB/CDB checks apply).
  - Lowest-index CDB channel with cdb_valid & cdb_alias==Qi_eff → its value, Q=0.
  - Vi_valid_from_rob → Vi_from_rob, Q=0.
  - Otherwise Q=Qi_eff and V=0.
- On go, at the next edge:
  - rob_* pulse 1 with the head fields.
  - rs_valid or lsb_valid pulses 1 (exactly one, per is_ls).
  - iss_* are loaded; iss_alias = cur_alias_from_rob.
  - rename_valid = (rd!=0); rename_reg/rename_alias are loaded.
- No go: all valid outputs clear to 0 at the next edge; data outputs hold.
- rollback (rdy-independent) clears FIFO pointers/count and all valid outputs, including rename_valid (kills the bypass). in_valid that cycle is dropped.
- rdy low: nothing changes, outputs hold (valids included).
- rst: all registers and outputs 0; in_ready is 1 once rst is low.

## Timing
- Accept at edge t → earliest dispatch outputs valid after edge t+1. Minimum latency 2 cycles from in_valid to rob_valid.
- Throughput: 1 instruction/cycle when no stall.
- Bypass window: rename_valid is high for the cycle after dispatch, which covers the RF update being one cycle behind. It does not depend on a later RF write.
- CDB/ROB capture is sampled in the dispatch cycle. A broadcast one cycle later is the RS/LSB's responsibility.
- Full: at count==DEPTH with go, in_ready is still 0 (no pass-through).

## Test plan
- Reset mid-stream: 3 entries queued, assert rst asynchronously → all valids 0 and count 0 immediately; in_ready=1 after release.
- Back-to-back dependency: `addi x1,x0,5` (alias 3) then `add x2,x1,x1` with RF Qi=0 stale → second issue has iss_Qi=iss_Qj=3. With cdb_valid[0] & alias 3 = 5 in that cycle → Q=0, V=5.
- Per-unit backpressure: lsb_full=1, head=load, next=add → nothing dispatches (in-order). Release lsb_full → load then add on consecutive cycles.
- Fill/wrap: DEPTH=4, rob_full=1, push 4 → in_ready=0. Release → 4 dispatches in order with pcs 0,4,8,12. Push 4 more → pointers wrap, order preserved.
- Rollback with simultaneous push and dispatch-eligible head → next cycle count=0, all valids 0, pushed instruction never dispatched, no bypass to the next instruction.
- CDB priority: both channels match Qi with values 7/9 and ROB valid 11 → iss_Vi=7.
